// File: rtl/fmul_arbiter.sv
// Two-port round-robin front end sharing one single-precision multiplier
// through a fixed two-stage pipeline (operand register, result register).
`default_nettype none

module fmul (
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic [31:0] y,
    output logic        ovf,
    output logic        udf
);
    // Denormal inputs are treated as zero and results below the normal range
    // flush to signed zero with udf; rounding is to nearest, ties to even.
    logic               sign;
    logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [47:0]        prod;
    logic [23:0]        mant;
    logic               guard, sticky;
    logic [24:0]        mant_r;
    logic [22:0]        frac_r;
    logic signed [10:0] exp_n, exp_r;

    always_comb begin
        y      = 32'd0;
        ovf    = 1'b0;
        udf    = 1'b0;
        sign   = x1[31] ^ x2[31];
        a_nan  = (x1[30:23] == 8'hFF) && (x1[22:0] != 23'd0);
        b_nan  = (x2[30:23] == 8'hFF) && (x2[22:0] != 23'd0);
        a_inf  = (x1[30:23] == 8'hFF) && (x1[22:0] == 23'd0);
        b_inf  = (x2[30:23] == 8'hFF) && (x2[22:0] == 23'd0);
        a_zero = (x1[30:23] == 8'h00);
        b_zero = (x2[30:23] == 8'h00);
        prod   = {24'd0, 1'b1, x1[22:0]} * {24'd0, 1'b1, x2[22:0]};
        exp_n  = $signed({3'b000, x1[30:23]}) + $signed({3'b000, x2[30:23]}) - 11'sd127;
        if (prod[47]) begin
            mant   = prod[47:24];
            guard  = prod[23];
            sticky = |prod[22:0];
            exp_n  = exp_n + 11'sd1;
        end else begin
            mant   = prod[46:23];
            guard  = prod[22];
            sticky = |prod[21:0];
        end
        mant_r = {1'b0, mant} + {24'd0, guard & (sticky | mant[0])};
        exp_r  = exp_n + (mant_r[24] ? 11'sd1 : 11'sd0);
        frac_r = mant_r[24] ? mant_r[23:1] : mant_r[22:0];

        if (a_nan || b_nan) begin
            y = 32'h7FC0_0000;
        end else if (a_inf || b_inf) begin
            y = (a_zero || b_zero) ? 32'h7FC0_0000 : {sign, 8'hFF, 23'd0};
        end else if (a_zero || b_zero) begin
            y = {sign, 31'd0};
        end else if (exp_r > 11'sd254) begin
            y   = {sign, 8'hFF, 23'd0};
            ovf = 1'b1;
        end else if (exp_r < 11'sd1) begin
            y   = {sign, 31'd0};
            udf = 1'b1;
        end else begin
            y = {sign, exp_r[7:0], frac_r};
        end
    end
endmodule

module fmul_arbiter (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in0_valid,
    output logic        in0_ready,
    input  logic [31:0] in0_x1,
    input  logic [31:0] in0_x2,
    input  logic        in1_valid,
    output logic        in1_ready,
    input  logic [31:0] in1_x1,
    input  logic [31:0] in1_x2,
    output logic        out_valid,
    output logic        out_id,
    output logic [31:0] out_y,
    output logic        out_ovf,
    output logic        out_udf,
    output logic        busy
);
    logic        last_grant;
    logic        grant_any;
    logic        grant_id;
    logic        v1, s1_id;
    logic [31:0] s1_x1, s1_x2;
    logic [31:0] f_y;
    logic        f_ovf, f_udf;
    logic        v2, s2_id, s2_ovf, s2_udf;
    logic [31:0] s2_y;

    // Gated by rstn so neither ready can be seen while reset is held.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = 1'b0;
        if (rstn) begin
            if (in0_valid && in1_valid) begin
                grant_any = 1'b1;
                grant_id  = ~last_grant;
            end else if (in0_valid) begin
                grant_any = 1'b1;
            end else if (in1_valid) begin
                grant_any = 1'b1;
                grant_id  = 1'b1;
            end
        end
    end

    assign in0_ready = grant_any & ~grant_id;
    assign in1_ready = grant_any & grant_id;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_grant <= 1'b1;
            v1         <= 1'b0;
            s1_id      <= 1'b0;
            s1_x1      <= 32'd0;
            s1_x2      <= 32'd0;
            v2         <= 1'b0;
            s2_id      <= 1'b0;
            s2_y       <= 32'd0;
            s2_ovf     <= 1'b0;
            s2_udf     <= 1'b0;
        end else begin
            v1 <= grant_any;
            if (grant_any) begin
                last_grant <= grant_id;
                s1_id      <= grant_id;
                s1_x1      <= grant_id ? in1_x1 : in0_x1;
                s1_x2      <= grant_id ? in1_x2 : in0_x2;
            end
            v2     <= v1;
            s2_id  <= s1_id;
            s2_y   <= f_y;
            s2_ovf <= f_ovf;
            s2_udf <= f_udf;
        end
    end

    fmul u_fmul (
        .x1  (s1_x1),
        .x2  (s1_x2),
        .y   (f_y),
        .ovf (f_ovf),
        .udf (f_udf)
    );

    assign out_valid = v2;
    assign out_id    = s2_id;
    assign out_y     = s2_y;
    assign out_ovf   = s2_ovf;
    assign out_udf   = s2_udf;
    assign busy      = v1 | v2;
endmodule

`default_nettype wire
